// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: state encoding for shift_register_ctrl (PARITY exists only with SHIFT_CTRL_PARITY_EN)
package shift_ctrl_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SHIFT_CTRL_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SHIFT = ST_SHIFT,
`ifdef SHIFT_CTRL_PARITY_EN
    PARITY = ST_PARITY,
`endif
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/shift_register_ctrl_if.sv
// shift_register_ctrl_if: parallel-word input handshake and serial output toward the downstream shift register
interface shift_register_ctrl_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic pause;
  logic sdo;
  logic shift_en;
  logic frame;
  logic done;
  modport master (output din, din_valid, pause, input din_ready, sdo, shift_en, frame, done);
  modport slave (input din, din_valid, pause, output din_ready, sdo, shift_en, frame, done);
endinterface

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: loads WIDTH-1, decrements on enable, saturates at zero
module shift_bit_counter #(parameter int WIDTH = 4) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LOAD = CW'(WIDTH - 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= rst ? '0 : i_load ? LOAD : (i_dec && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/shift_register_ctrl.sv
// shift_register_ctrl: serializes a parallel word MSB first; SHIFT_CTRL_PARITY_EN appends an even-parity bit
module shift_register_ctrl
  import shift_ctrl_pkg::*;
#(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst,
  shift_register_ctrl_if.slave bus
);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_hold;
  logic w_xfer, w_adv, w_zero, w_frame;
  assign w_xfer = r_state == IDLE && bus.din_valid;
  assign w_adv = r_state == SHIFT && !bus.pause;
  shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .rst(rst), .i_load(w_xfer), .i_dec(w_adv), .o_zero(w_zero)
  );
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk)
    r_hold <= rst ? '0 : w_xfer ? bus.din : w_adv ? {r_hold[WIDTH-2:0], 1'b0} : r_hold;
`ifdef SHIFT_CTRL_PARITY_EN
  // parity is taken at capture because the hold register is consumed by shifting
  logic r_par;
  always_ff @(posedge clk) r_par <= rst ? 1'b0 : w_xfer ? ^bus.din : r_par;
  assign w_frame = r_state == SHIFT || r_state == PARITY;
`else
  assign w_frame = r_state == SHIFT;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_xfer ? SHIFT : IDLE;
`ifdef SHIFT_CTRL_PARITY_EN
      SHIFT: w_next = (w_adv && w_zero) ? PARITY : SHIFT;
      PARITY: w_next = bus.pause ? PARITY : DONE;
`else
      SHIFT: w_next = (w_adv && w_zero) ? DONE : SHIFT;
`endif
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.din_ready = r_state == IDLE;
    bus.frame = w_frame;
    bus.shift_en = w_frame && !bus.pause;
    bus.done = r_state == DONE;
`ifdef SHIFT_CTRL_PARITY_EN
    bus.sdo = r_state == SHIFT ? r_hold[WIDTH-1] : r_state == PARITY ? r_par : 1'b0;
`else
    bus.sdo = r_state == SHIFT ? r_hold[WIDTH-1] : 1'b0;
`endif
  end
endmodule

// File: tb/tb_shift_register_ctrl.sv
// tb_shift_register_ctrl: directed steps with a bit/word scoreboard and a model of the downstream shift register
module tb_shift_register_ctrl;
`ifdef SHIFT_CTRL_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  logic exp_bits[$];
  logic [3:0] exp_out[$];
  logic [3:0] ds = '0;
  shift_register_ctrl_if #(.WIDTH(4)) bus ();
  shift_register_ctrl #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // scoreboard: expectations pushed when a transfer is set up, popped as bits/done appear
  always @(negedge clk) begin
    logic [3:0] w;
    if (bus.shift_en === 1'b1) begin
      chk("sb_bit_pending", 32'(exp_bits.size() > 0), 1);
      if (exp_bits.size() > 0) chk("sb_bit", bus.sdo, exp_bits.pop_front());
      chk("sb_frame", bus.frame, 1);
      ds = {ds[2:0], bus.sdo};
    end
    if (bus.done === 1'b1) begin
      chk("sb_done_pending", 32'(exp_out.size() > 0), 1);
      if (exp_out.size() > 0) chk("sb_ds_out", ds, exp_out.pop_front());
    end
    if (rst) begin
      exp_bits.delete();
      exp_out.delete();
    end else if (bus.din_valid === 1'b1 && bus.din_ready === 1'b1) begin
      w = bus.din;
      for (int i = 3; i >= 0; i--) exp_bits.push_back(w[i]);
      if (PB == 1) exp_bits.push_back(^w);
      exp_out.push_back(PB == 1 ? {w[2:0], ^w} : w);
    end
  end

  task automatic run_word(input logic [3:0] w, input int p0, input int p1, input int exp_done);
    int c;
    nxt();
    bus.din = w;
    bus.din_valid = 1;
    nxt();
    bus.din_valid = 0;
    c = 1;
    while (c < 40) begin
      bus.pause = c >= p0 && c <= p1;
      smp();
      if (bus.done) break;
      if (c >= p0 && c <= p1) begin
        chk("pause_se", bus.shift_en, 0);
        chk("pause_sdo", bus.sdo, w[4-p0]);
      end
      c++;
      nxt();
    end
    chk("done_cyc", c, exp_done);
    chk("done_frame", bus.frame, 0);
    chk("done_se", bus.shift_en, 0);
    chk("done_sdo", bus.sdo, 0);
    bus.pause = 0;
    nxt();
    smp();
    chk("idle_ready", bus.din_ready, 1);
    chk("idle_done", bus.done, 0);
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (c < 40) begin
      smp();
      c++;
      if (bus.done) break;
      nxt();
    end
  endtask

  initial begin
    int c;
    bus.din = '0;
    bus.din_valid = 0;
    bus.pause = 0;
    nxt();
    smp();
    chk("rst_ready", bus.din_ready, 1);
    chk("rst_sdo", bus.sdo, 0);
    chk("rst_se", bus.shift_en, 0);
    chk("rst_frame", bus.frame, 0);
    chk("rst_done", bus.done, 0);
    nxt();
    rst = 0;
    // 1011 unpaused: bits 1,0,1,1 on cycles 1-4
    nxt();
    bus.din = 4'b1011;
    bus.din_valid = 1;
    nxt();
    bus.din_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      smp();
      chk("a_se", bus.shift_en, 1);
      chk("a_ready", bus.din_ready, 0);
      chk("a_sdo", bus.sdo, i == 2 ? 0 : 1);
      nxt();
    end
    if (PB == 1) begin
      smp();
      chk("a_par", bus.sdo, 1);
      nxt();
    end
    smp();
    chk("a_done", bus.done, 1);
    chk("a_ds", ds, PB == 1 ? 4'b0111 : 4'b1011);
    nxt();
    smp();
    chk("a_idle", bus.din_ready, 1);
    run_word(4'b0110, 0, -1, 5 + PB);
    run_word(4'b1100, 2, 3, 7 + PB);
    run_word(4'b0101, 1, 1, 6 + PB);
    // din_valid held: second word only accepted after DONE
    nxt();
    bus.din = 4'b1111;
    bus.din_valid = 1;
    nxt();
    smp();
    chk("h_ready1", bus.din_ready, 0);
    nxt();
    bus.din = 4'b0001;
    smp();
    chk("h_ready2", bus.din_ready, 0);
    chk("h_sdo2", bus.sdo, 1);
    nxt();
    wait_done(c);
    chk("h_done1", c, 3 + PB);
    nxt();
    smp();
    chk("h_idle", bus.din_ready, 1);
    nxt();
    bus.din_valid = 0;
    wait_done(c);
    chk("h_done2", c, 5 + PB);
    // reset on cycle 2 aborts the frame
    nxt();
    bus.din = 4'b1010;
    bus.din_valid = 1;
    nxt();
    bus.din_valid = 0;
    smp();
    nxt();
    rst = 1;
    smp();
    chk("r_mid_frame", bus.frame, 1);
    nxt();
    rst = 0;
    smp();
    chk("r_ready", bus.din_ready, 1);
    chk("r_frame", bus.frame, 0);
    chk("r_se", bus.shift_en, 0);
    for (int i = 0; i < 6; i++) begin
      nxt();
      smp();
      chk("r_no_done", bus.done, 0);
    end
    // reset together with a transfer drops the word
    nxt();
    bus.din = 4'b0101;
    bus.din_valid = 1;
    rst = 1;
    nxt();
    rst = 0;
    bus.din_valid = 0;
    smp();
    chk("rv_frame", bus.frame, 0);
    chk("rv_ready", bus.din_ready, 1);
    nxt();
    smp();
    chk("rv_frame2", bus.frame, 0);
    chk("sb_empty", 32'(exp_bits.size()), 0);
    chk("sb_out_empty", 32'(exp_out.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_register_ctrl.md
SHIFT_REGISTER_CTRL -- requirements
Module: shift_register_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, bits per serialized word (>= 2).
REQ-002 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: din  input  WIDTH  parallel word to serialize.
REQ-005 Port: din_valid  input  1  din is valid.
REQ-006 Port: din_ready  output  1  controller accepts a word this cycle.
REQ-007 Port: pause  input  1  stall request from the downstream shift register.
REQ-008 Port: sdo  output  1  serial bit; drives the shift register's in.
REQ-009 Port: shift_en  output  1  downstream shift register samples sdo on this edge.
REQ-010 Port: frame  output  1  high while a word (and parity, if present) is being emitted.
REQ-011 Port: done  output  1  one-cycle pulse after the last bit.

Function
REQ-012 States SHALL be IDLE, SHIFT, PARITY (only with PARITY_EN), DONE.
REQ-013 IDLE: din_ready=1, all other outputs 0.
REQ-014 Transfer SHALL occur on the posedge where din_valid && din_ready; din is captured into a hold register, bit counter loads WIDTH-1, next state SHIFT.
REQ-015 din_ready SHALL be 0 in SHIFT, PARITY and DONE; din_valid there is ignored, with no capture.
REQ-016 SHIFT: frame=1; sdo = hold[WIDTH-1] (MSB first); shift_en = !pause.
REQ-017 SHIFT with pause=0: hold shifts left one bit, counter decrements; with pause=1: hold, counter and state frozen, sdo held stable.
REQ-018 SHIFT with pause=0 and counter==0: next state PARITY if PARITY_EN, else DONE.
REQ-019 DONE: done=1, frame=0, shift_en=0, sdo=0; next state IDLE unconditionally (pause ignored).
REQ-020 Latency without parity: first bit valid the cycle after transfer; exactly WIDTH shift_en cycles when unpaused; done the cycle after the last bit; next transfer possible 2 cycles after done is asserted (DONE, then IDLE).
REQ-021 Counter width SHALL be $clog2(WIDTH); no wrap beyond 0 while in SHIFT.
REQ-022 pause in IDLE or DONE SHALL have no effect.

Reset
REQ-023 rst=1 at a posedge SHALL force IDLE regardless of state, clearing hold and counter.
REQ-024 Reset values: din_ready=1 once in IDLE; sdo, shift_en, frame, done = 0.
REQ-025 Reset mid-frame SHALL abort the word: no done pulse, no further shift_en.
REQ-026 rst SHALL take priority over a simultaneous transfer; that word is dropped.

Configuration
REQ-027 Macro SHIFT_CTRL_PARITY_EN defined: after the WIDTH data bits, PARITY state emits sdo = even parity (XOR of the captured word), with frame=1 and shift_en = !pause; PARITY is stalled by pause like SHIFT; then DONE.
REQ-028 Macro undefined: no PARITY state, no parity logic; SHIFT goes directly to DONE.

Structure
REQ-029 Package shift_ctrl_pkg SHALL hold the state enum typedef and state encoding localparams.
REQ-030 One sub-module, shift_bit_counter (load, decrement-enable, zero flag), SHALL implement the bit counter.

Verification (WIDTH=4, controller sdo/shift_en driving shift_register_behavioral as the downstream register)
REQ-031 Transfer 4'b1011, pause=0 -> sdo 1,0,1,1 on cycles 1-4 after transfer; shift_en high for those 4 cycles; done on cycle 5; downstream out==4'b1011.
REQ-032 PARITY_EN, transfer 4'b1011 -> 4 data bits, then parity bit 1 on cycle 5, done on cycle 6; transfer 4'b0110 -> parity bit 0.
REQ-033 Transfer 4'b1100, pause=1 on cycles 2-3 -> sdo held at 1 with shift_en=0 during the pause; the 4 bits resume in order; done on cycle 7.
REQ-034 din_valid=1 held continuously with 4'b1111, then 4'b0001 presented mid-frame -> only 4'b1111 shifted; 4'b0001 accepted in the IDLE after done.
REQ-035 rst=1 on cycle 2 of a frame -> next cycle IDLE, din_ready=1, frame=0, no done pulse; rst asserted together with din_valid in IDLE -> no capture.
